// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
package imem_loader_pkg;

  localparam int         PC_W      = 16;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_H,
    ADDR_L,
    CNT_H,
    CNT_L,
    DATA_H,
    DATA_L,
    CSUM
  } state_e;

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte watchdog: a loadable down-counter that flags expiry after
// TIMEOUT_CYC consecutive enabled cycles without a clear.
module imem_loader_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;

  // A clear in the expiry cycle wins, so a late byte is still accepted.
  assign expired_o = en_i && !clear_i && (cnt_q == '0);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Parses framed load commands from the UART byte stream and writes 16-bit
// words into instruction memory, holding the CPU while a frame is in flight.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int              DEPTH       = 4096,
  parameter logic [PC_W-1:0] RESET_PC    = 16'd100,
  parameter int              TIMEOUT_CYC = 100000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            load_busy,
  output logic            wr_en,
  output logic [PC_W-1:0] wr_addr,
  output logic [PC_W-1:0] wr_data,
  output logic            load_done,
  output logic            load_err,
  output logic [PC_W-1:0] boot_pc
);

  state_e          state_q;
  logic [PC_W-1:0] start_q, addr_q, cnt_q;
  logic [PC_W-1:0] wr_addr_q, wr_data_q, boot_pc_q;
  logic [7:0]      hi_q, csum_q;
  logic            load_busy_q, wr_en_q, load_done_q, load_err_q;
  logic            tmo_expired;

  logic [16:0]     end_d;
  logic            range_bad_d, cnt_zero_d;

  imem_loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (rx_valid || (state_q == IDLE)),
    .en_i     (state_q != IDLE),
    .expired_o(tmo_expired)
  );

  // Range check uses the count formed from CNT_H and the CNT_L byte on the bus.
  assign end_d       = {1'b0, start_q} + {1'b0, cnt_q[15:8], rx_data};
  assign range_bad_d = end_d > 17'(DEPTH);
  assign cnt_zero_d  = ({cnt_q[15:8], rx_data} == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      start_q     <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      hi_q        <= '0;
      csum_q      <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      boot_pc_q   <= RESET_PC;
      load_busy_q <= 1'b0;
      wr_en_q     <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      if (rx_valid) begin
        if (state_q != IDLE && state_q != CSUM) csum_q <= csum_q + rx_data;
        case (state_q)
          IDLE: if (rx_data == SYNC_BYTE) begin
            state_q     <= ADDR_H;
            csum_q      <= '0;
            load_busy_q <= 1'b1;
          end
          ADDR_H: begin start_q[15:8] <= rx_data; state_q <= ADDR_L; end
          ADDR_L: begin start_q[7:0]  <= rx_data; state_q <= CNT_H;  end
          CNT_H:  begin cnt_q[15:8]   <= rx_data; state_q <= CNT_L;  end
          CNT_L: begin
            if (range_bad_d) begin
              state_q     <= IDLE;
              load_busy_q <= 1'b0;
              load_err_q  <= 1'b1;
            end else begin
              cnt_q[7:0] <= rx_data;
              addr_q     <= start_q;
              state_q    <= cnt_zero_d ? CSUM : DATA_H;
            end
          end
          DATA_H: begin hi_q <= rx_data; state_q <= DATA_L; end
          DATA_L: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= {hi_q, rx_data};
            addr_q    <= addr_q + 16'd1;
            cnt_q     <= cnt_q - 16'd1;
            state_q   <= (cnt_q == 16'd1) ? CSUM : DATA_H;
          end
          CSUM: begin
            state_q     <= IDLE;
            load_busy_q <= 1'b0;
            if (rx_data == csum_q) begin
              load_done_q <= 1'b1;
              boot_pc_q   <= start_q;
            end else begin
              load_err_q  <= 1'b1;
            end
          end
          default: begin state_q <= IDLE; load_busy_q <= 1'b0; end
        endcase
      end else if (tmo_expired) begin
        state_q     <= IDLE;
        load_busy_q <= 1'b0;
        load_err_q  <= 1'b1;
      end
    end
  end

  assign load_busy = load_busy_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;
  assign boot_pc   = boot_pc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the test plan plus
// randomized frames scored against a frame-level reference model.
module tb_imem_loader;

  localparam int          DEPTH = 4096;
  localparam int          T     = 40;
  localparam logic [15:0] RPC   = 16'd100;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        load_busy, wr_en, load_done, load_err;
  logic [15:0] wr_addr, wr_data, boot_pc;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] got_wr[$];
  logic [15:0] words_q[$];
  int          done_cnt, err_cnt;
  logic [15:0] exp_boot;

  imem_loader #(
    .DEPTH      (DEPTH),
    .RESET_PC   (RPC),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .load_busy(load_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .load_done(load_done),
    .load_err (load_err),
    .boot_pc  (boot_pc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en)     got_wr.push_back({wr_addr, wr_data});
      if (load_done) done_cnt++;
      if (load_err)  err_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Strobes one byte after `gap` idle cycles; returns 1 time unit after the
  // sampling edge, so registered reactions to this byte are already visible.
  task automatic put(input logic [7:0] b, input int gap);
    idle(gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int idx, input int stall_idx, input int max_gap);
    return (idx == stall_idx) ? T - 1 : int'($urandom_range(0, max_gap));
  endfunction

  task automatic clear_obs();
    got_wr.delete();
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // Sends one frame built from addr/words_q and scores it against the
  // expected outcome derived from the frame format rules.
  task automatic run_frame(input string name, input logic [15:0] addr, input bit bad_csum,
                           input int max_gap, input int stall_idx);
    int          cnt = words_q.size();
    int          idx = 0;
    logic [7:0]  sum = 8'h00;
    logic [7:0]  hdr[4];
    bit          range_bad;
    int          exp_n;
    clear_obs();
    range_bad = (int'(addr) + cnt) > DEPTH;
    hdr[0] = addr[15:8];
    hdr[1] = addr[7:0];
    hdr[2] = 8'(cnt >> 8);
    hdr[3] = 8'(cnt);
    put(8'hA5, pick_gap(idx++, stall_idx, max_gap));
    check({name, "_busy_rise"}, load_busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      put(hdr[i], pick_gap(idx, stall_idx, max_gap));
      if (idx == stall_idx) check({name, "_stall_cancel"}, load_busy, 1'b1);
      idx++;
      sum += hdr[i];
    end
    if (range_bad) begin
      check({name, "_range_err"}, load_err, 1'b1);
      check({name, "_range_busy"}, load_busy, 1'b0);
    end else begin
      for (int w = 0; w < cnt; w++) begin
        put(words_q[w][15:8], pick_gap(idx++, stall_idx, max_gap));
        check({name, "_no_early_wr"}, wr_en, 1'b0);
        put(words_q[w][7:0], pick_gap(idx++, stall_idx, max_gap));
        check({name, "_wr_en"}, wr_en, 1'b1);
        check({name, "_wr_addr"}, wr_addr, addr + 16'(w));
        check({name, "_wr_data"}, wr_data, words_q[w]);
        sum += words_q[w][15:8] + words_q[w][7:0];
      end
      put(bad_csum ? sum + 8'd1 : sum, pick_gap(idx++, stall_idx, max_gap));
      check({name, "_done"}, load_done, !bad_csum);
      check({name, "_err"},  load_err,  bad_csum);
      check({name, "_busy_fall"}, load_busy, 1'b0);
      if (!bad_csum) exp_boot = addr;
    end
    idle(2);
    exp_n = range_bad ? 0 : cnt;
    check({name, "_n_writes"}, got_wr.size(), exp_n);
    if (got_wr.size() == exp_n)
      for (int w = 0; w < exp_n; w++)
        check({name, "_wr_log"}, got_wr[w], {addr + 16'(w), words_q[w]});
    check({name, "_n_done"}, done_cnt, (!range_bad && !bad_csum) ? 1 : 0);
    check({name, "_n_err"},  err_cnt,  (range_bad || bad_csum) ? 1 : 0);
    check({name, "_boot_pc"}, boot_pc, exp_boot);
  endtask

  task automatic plan_words();
    words_q.delete();
    words_q.push_back(16'h0D00);
    words_q.push_back(16'h0D41);
  endtask

  initial begin
    bit early;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    exp_boot = RPC;
    clear_obs();
    idle(3);
    check("rst_busy", load_busy, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_err", load_err, 1'b0);
    check("rst_wr_addr", wr_addr, 16'h0000);
    check("rst_wr_data", wr_data, 16'h0000);
    check("rst_boot_pc", boot_pc, RPC);
    reset = 1'b0;
    idle(1);

    plan_words();
    run_frame("good", 16'h0064, 1'b0, 2, -1);
    exp_boot = 16'h0064;

    // Bad checksum leaves boot_pc alone; start from a known value first.
    reset = 1'b1; idle(1); reset = 1'b0; idle(1);
    exp_boot = RPC;
    plan_words();
    run_frame("bad_csum", 16'h0064, 1'b1, 2, -1);

    plan_words();
    run_frame("range", 16'h0FFF, 1'b0, 0, -1);
    clear_obs();
    put(8'h0D, 0);
    put(8'h00, 1);
    idle(2);
    check("range_ignore_busy", load_busy, 1'b0);
    check("range_ignore_err", err_cnt, 0);
    check("range_ignore_wr", got_wr.size(), 0);

    words_q.delete();
    run_frame("zero_cnt", 16'h012C, 1'b0, 1, -1);

    clear_obs();
    put(8'h00, 0); put(8'hFF, 0); put(8'h5A, 0);
    check("garbage_busy", load_busy, 1'b0);
    check("garbage_err", err_cnt, 0);
    plan_words();
    run_frame("b2b_good", 16'h0064, 1'b0, 0, -1);

    // Byte arriving in the very cycle the timeout would expire is accepted.
    plan_words();
    run_frame("tmo_cancel", 16'h0222, 1'b0, 0, 3);

    clear_obs();
    put(8'hA5, 0); put(8'h00, 0); put(8'h64, 0);
    early = 1'b0;
    for (int i = 1; i <= T; i++) begin
      @(posedge clk); #1;
      if (i < T && (load_err || !load_busy)) early = 1'b1;
    end
    check("tmo_early", early, 1'b0);
    check("tmo_err", load_err, 1'b1);
    check("tmo_busy", load_busy, 1'b0);
    idle(2);
    check("tmo_n_err", err_cnt, 1);
    check("tmo_boot_pc", boot_pc, exp_boot);

    clear_obs();
    put(8'hA5, 0); put(8'h00, 0); put(8'h64, 0); put(8'h00, 0); put(8'h02, 0); put(8'h0D, 0);
    rx_data  = 8'h00;
    rx_valid = 1'b1;
    reset    = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    reset    = 1'b0;
    exp_boot = RPC;
    check("rst_mid_wr_en", wr_en, 1'b0);
    check("rst_mid_busy", load_busy, 1'b0);
    idle(3);
    check("rst_mid_n_wr", got_wr.size(), 0);
    check("rst_mid_pulses", done_cnt + err_cnt, 0);
    check("rst_mid_boot_pc", boot_pc, RPC);

    for (int r = 0; r < 30; r++) begin
      int          cnt = $urandom_range(0, 6);
      logic [15:0] addr;
      words_q.delete();
      for (int w = 0; w < cnt; w++) words_q.push_back(16'($urandom));
      if ($urandom_range(0, 3) == 0) addr = 16'(DEPTH - cnt + int'($urandom_range(0, 1)));
      else                           addr = 16'($urandom_range(0, DEPTH - 1));
      run_frame("rand", addr, $urandom_range(0, 3) == 0, (r % 2 == 0) ? 3 : 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
